// File: rtl/bch_dec_corr.sv
// Serial DEC BCH corrector: locator from S1/S3, one-bit-per-clock Chien search.
// Define BCH_DEC_ZERO_BYPASS_EN to skip the search when both syndromes are zero.
module bch_dec_corr #(
  parameter int P_GF_M     = 5,
  parameter int P_CW_WIDTH = 2**P_GF_M-1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_vld_i,
  output logic                  s_rdy_o,
  input  logic [P_GF_M-1:0]     s1_i,
  input  logic [P_GF_M-1:0]     s3_i,
  input  logic [P_CW_WIDTH-1:0] cw_i,
  output logic [P_CW_WIDTH-1:0] cw_o,
  output logic [1:0]            err_cnt_o,
  output logic                  uncorr_o,
  output logic                  o_vld_o,
  input  logic                  o_rdy_i
);

  localparam int LP_IW = $clog2(P_CW_WIDTH);
  localparam logic [P_GF_M-1:0] LP_RED =
    P_GF_M'((P_GF_M == 5) ? 5 :
            (P_GF_M == 6) ? 3 :
            (P_GF_M == 7) ? 9 : 29);
  localparam logic [LP_IW-1:0] LP_LAST = LP_IW'(P_CW_WIDTH-1);

  typedef enum logic [1:0] {
    ST_IDLE, ST_LOAD, ST_SEARCH, ST_DONE
  } state_t;

  function automatic logic [P_GF_M-1:0] gf_mul(
    input logic [P_GF_M-1:0] a,
    input logic [P_GF_M-1:0] b
  );
    logic [P_GF_M-1:0] p;
    logic [P_GF_M-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < P_GF_M; k++) begin
      if (b[k]) p = p ^ x;
      x = x[P_GF_M-1] ? ((x << 1) ^ LP_RED) : (x << 1);
    end
    return p;
  endfunction

  // Multiply by alpha^-1: undo one shift of the LFSR
  function automatic logic [P_GF_M-1:0] gf_div_a(
    input logic [P_GF_M-1:0] t
  );
    logic [P_GF_M-1:0] w;
    w = t ^ (t[0] ? LP_RED : '0);
    return {t[0], w[P_GF_M-1:1]};
  endfunction

  state_t                r_state;
  logic                  r_s_rdy;
  logic                  r_o_vld;
  logic [P_GF_M-1:0]     r_s1;
  logic [P_GF_M-1:0]     r_s3;
  logic [P_GF_M-1:0]     r_t1;
  logic [P_GF_M-1:0]     r_t2;
  logic [P_CW_WIDTH-1:0] r_cw;
  logic [P_CW_WIDTH-1:0] r_cw_fix;
  logic [P_CW_WIDTH-1:0] r_cw_o;
  logic [LP_IW-1:0]      r_idx;
  logic [1:0]            r_cnt;
  logic [1:0]            r_err;
  logic                  r_unc;

  logic [P_GF_M-1:0]     w_s1sq;
  logic [P_GF_M-1:0]     w_s1cu;
  logic [P_GF_M-1:0]     w_e;
  logic                  w_hit;
  logic [1:0]            w_cnt_nxt;
  logic [1:0]            w_exp;
  logic                  w_unc;
  logic [P_CW_WIDTH-1:0] w_cw_nxt;

  always_comb begin
    w_s1sq    = gf_mul(r_s1, r_s1);
    w_s1cu    = gf_mul(w_s1sq, r_s1);
    w_e       = r_s1 ^ r_t1 ^ r_t2;
    w_hit     = (w_e == '0) && (r_s1 != '0);
    w_cnt_nxt = (w_hit && r_cnt != 2'd3) ? r_cnt + 2'd1 : r_cnt;
    w_cw_nxt  = r_cw_fix;
    w_cw_nxt[r_idx] = r_cw_fix[r_idx] ^ w_hit;
    w_exp     = (r_s1 == '0) ? 2'd0 :
                (r_s3 == w_s1cu) ? 2'd1 : 2'd2;
    w_unc     = ((r_s1 == '0) && (r_s3 != '0)) ||
                (w_cnt_nxt != w_exp);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_s_rdy <= 1'b1;
      r_o_vld <= 1'b0;
      r_cw_o  <= '0;
      r_err   <= '0;
      r_unc   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (s_vld_i && r_s_rdy) begin
            r_s1     <= s1_i;
            r_s3     <= s3_i;
            r_cw     <= cw_i;
            r_cw_fix <= cw_i;
            r_s_rdy  <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_t1  <= w_s1sq;
          r_t2  <= r_s3 ^ w_s1cu;
          r_idx <= '0;
          r_cnt <= '0;
          r_state <= ST_SEARCH;
`ifdef BCH_DEC_ZERO_BYPASS_EN
          if (r_s1 == '0 && r_s3 == '0) begin
            r_cw_o  <= r_cw;
            r_err   <= '0;
            r_unc   <= 1'b0;
            r_o_vld <= 1'b1;
            r_state <= ST_DONE;
          end
`endif
        end
        ST_SEARCH: begin
          r_cw_fix <= w_cw_nxt;
          r_cnt    <= w_cnt_nxt;
          r_t1     <= gf_div_a(r_t1);
          r_t2     <= gf_div_a(gf_div_a(r_t2));
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LP_LAST) begin
            r_cw_o  <= w_unc ? r_cw : w_cw_nxt;
            r_err   <= w_unc ? 2'd0 : w_cnt_nxt;
            r_unc   <= w_unc;
            r_o_vld <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (o_rdy_i) begin
            r_o_vld <= 1'b0;
            r_s_rdy <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_rdy_o   = r_s_rdy;
  assign o_vld_o   = r_o_vld;
  assign cw_o      = r_cw_o;
  assign err_cnt_o = r_err;
  assign uncorr_o  = r_unc;

endmodule

// File: tb/tb_bch_dec_corr.sv
// Bench for bch_dec_corr (M=5): directed cases plus random error patterns
// checked against a brute-force syndrome-space decoder.
module tb_bch_dec_corr;

  localparam int M = 5;
  localparam int N = 31;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_vld = 1'b0;
  logic         s_rdy;
  logic [M-1:0] s1 = '0;
  logic [M-1:0] s3 = '0;
  logic [N-1:0] cw_in = '0;
  logic [N-1:0] cw_out;
  logic [1:0]   err_cnt;
  logic         uncorr;
  logic         o_vld;
  logic         o_rdy = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [M-1:0] alog [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bch_dec_corr #(.P_GF_M(M)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_vld_i(s_vld), .s_rdy_o(s_rdy),
    .s1_i(s1), .s3_i(s3), .cw_i(cw_in),
    .cw_o(cw_out), .err_cnt_o(err_cnt),
    .uncorr_o(uncorr), .o_vld_o(o_vld),
    .o_rdy_i(o_rdy)
  );

  function automatic void build_tables();
    logic [M:0] a;
    a = 1;
    for (int i = 0; i < N; i++) begin
      alog[i] = a[M-1:0];
      a = a << 1;
      if (a[M]) a = a ^ 6'h25;
    end
  endfunction

  function automatic void syn(input logic [N-1:0] w,
                              output logic [M-1:0] o1,
                              output logic [M-1:0] o3);
    o1 = '0;
    o3 = '0;
    for (int i = 0; i < N; i++)
      if (w[i]) begin
        o1 = o1 ^ alog[i];
        o3 = o3 ^ alog[(3*i) % N];
      end
  endfunction

  // Nearest-codeword decode of weight <= 2 purely from the syndromes
  function automatic void model(input logic [M-1:0] a1,
                                input logic [M-1:0] a3,
                                input logic [N-1:0] w,
                                output logic [N-1:0] ecw,
                                output logic [1:0] eerr,
                                output logic eunc);
    ecw = w; eerr = 0; eunc = 0;
    if (a1 == 0 && a3 == 0) return;
    for (int i = 0; i < N; i++)
      if (alog[i] == a1 && alog[(3*i) % N] == a3) begin
        ecw[i] = ~ecw[i]; eerr = 1; return;
      end
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if ((alog[i] ^ alog[j]) == a1 &&
            (alog[(3*i) % N] ^ alog[(3*j) % N]) == a3) begin
          ecw[i] = ~ecw[i]; ecw[j] = ~ecw[j]; eerr = 2; return;
        end
    eunc = 1;
  endfunction

  function automatic int exp_lat(input logic [M-1:0] a1,
                                 input logic [M-1:0] a3);
`ifdef BCH_DEC_ZERO_BYPASS_EN
    if (a1 == 0 && a3 == 0) return 1;
`endif
    return N + 1;
  endfunction

  // Present a word, wait for acceptance, then wait for the result.
  task automatic xfer(input logic [N-1:0] w, input logic [M-1:0] a1,
                      input logic [M-1:0] a3, output int lat, output bit ok);
    int k, t0;
    cw_in = w; s1 = a1; s3 = a3; s_vld = 1'b1;
    k = 0;
    while (!s_rdy && k < 200) begin @(posedge clk); #1; k++; end
    ok = s_rdy;
    @(posedge clk); #1;
    t0 = cyc;
    s_vld = 1'b0;
    k = 0;
    while (!o_vld && k < 100) begin @(posedge clk); #1; k++; end
    ok = ok && o_vld;
    lat = cyc - t0;
  endtask

  task automatic consume();
    o_rdy = 1'b1;
    @(posedge clk); #1;
    o_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_s_rdy got %b want 1", s_rdy); end
    n_vec++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL rst_o_vld got %b want 0", o_vld); end
    n_vec++; if (cw_out !== '0) begin n_bad++; $display("FAIL rst_cw got %h want 0", cw_out); end
    n_vec++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    n_vec++; if (uncorr !== 1'b0) begin n_bad++; $display("FAIL rst_unc got %b want 0", uncorr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string nm, input logic [N-1:0] w,
                               input logic [M-1:0] a1, input logic [M-1:0] a3,
                               input logic [N-1:0] xcw, input logic [1:0] xerr,
                               input logic xunc);
    int lat; bit ok;
    xfer(w, a1, a3, lat, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL %s_timeout no result", nm); end
    n_vec++; if (cw_out !== xcw) begin n_bad++; $display("FAIL %s_cw got %h want %h", nm, cw_out, xcw); end
    n_vec++; if (err_cnt !== xerr) begin n_bad++; $display("FAIL %s_err got %0d want %0d", nm, err_cnt, xerr); end
    n_vec++; if (uncorr !== xunc) begin n_bad++; $display("FAIL %s_unc got %b want %b", nm, uncorr, xunc); end
    n_vec++; if (lat !== exp_lat(a1, a3)) begin n_bad++; $display("FAIL %s_lat got %0d want %0d", nm, lat, exp_lat(a1, a3)); end
    consume();
    n_vec++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL %s_vld_drop got %b want 0", nm, o_vld); end
  endtask

  task automatic test_double();
    logic [N-1:0] w;
    logic [M-1:0] a1, a3;
    w = 31'h100008;
    syn(w, a1, a3);
    test_directed("double", w, a1, a3, '0, 2'd2, 1'b0);
  endtask

  task automatic test_random(input int cnt);
    logic [N-1:0] w, e, xcw;
    logic [M-1:0] a1, a3;
    logic [1:0] xerr;
    logic xunc;
    int lat, wt, p; bit ok;
    for (int v = 0; v < cnt; v++) begin
      e = '0;
      wt = $urandom_range(0, 3);
      while ($countones(e) < wt) begin
        p = $urandom_range(0, N - 1);
        e[p] = 1'b1;
      end
      syn(e, a1, a3);
      if ($urandom_range(0, 7) == 0) begin
        a1 = M'($urandom); a3 = M'($urandom);
      end
      w = N'($urandom);
      model(a1, a3, w, xcw, xerr, xunc);
      xfer(w, a1, a3, lat, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_timeout no result", v); end
      n_vec++; if (cw_out !== xcw) begin n_bad++; $display("FAIL rnd%0d_cw got %h want %h", v, cw_out, xcw); end
      n_vec++; if (err_cnt !== xerr) begin n_bad++; $display("FAIL rnd%0d_err got %0d want %0d", v, err_cnt, xerr); end
      n_vec++; if (uncorr !== xunc) begin n_bad++; $display("FAIL rnd%0d_unc got %b want %b", v, uncorr, xunc); end
      n_vec++; if (lat !== exp_lat(a1, a3)) begin n_bad++; $display("FAIL rnd%0d_lat got %0d want %0d", v, lat, exp_lat(a1, a3)); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] wa, wb, xa, xb;
    logic [M-1:0] a1, a3, b1, b3;
    logic [1:0] ea, eb;
    logic ua, ub;
    int lat; bit ok;
    wa = N'($urandom); wa[9] = ~wa[9];
    syn(31'h200, a1, a3);
    model(a1, a3, wa, xa, ea, ua);
    wb = N'($urandom);
    syn(31'h40000011, b1, b3);
    model(b1, b3, wb, xb, eb, ub);
    xfer(wa, a1, a3, lat, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_a_timeout no result"); end
    cw_in = wb; s1 = b1; s3 = b3; s_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++; if (o_vld !== 1'b1 || s_rdy !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d vld/rdy got %b/%b want 1/0", c, o_vld, s_rdy);
      end
      n_vec++; if (cw_out !== xa || err_cnt !== ea || uncorr !== ua) begin
        n_bad++; $display("FAIL bp_stable%0d got %h/%0d/%b want %h/%0d/%b", c, cw_out, err_cnt, uncorr, xa, ea, ua);
      end
    end
    consume();
    n_vec++; if (o_vld !== 1'b0 || s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL bp_release vld/rdy got %b/%b want 0/1", o_vld, s_rdy);
    end
    xfer(wb, b1, b3, lat, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_b_timeout no result"); end
    n_vec++; if (cw_out !== xb || err_cnt !== eb || uncorr !== ub) begin
      n_bad++; $display("FAIL bp_b got %h/%0d/%b want %h/%0d/%b", cw_out, err_cnt, uncorr, xb, eb, ub);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int k, seen;
    cw_in = 31'h80; s1 = 5'h14; s3 = 5'h18; s_vld = 1'b1;
    k = 0;
    while (!s_rdy && k < 200) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    s_vld = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_s_rdy got %b want 1", s_rdy); end
    n_vec++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rst_o_vld got %b want 0", o_vld); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (o_vld) seen++;
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL mid_rst_ghost got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_directed("clean", '0, 5'h00, 5'h00, '0, 2'd0, 1'b0);
    test_directed("single", 31'h80, 5'h14, 5'h18, '0, 2'd1, 1'b0);
    test_double();
    test_directed("uncorr", 31'h5, 5'h00, 5'h01, 31'h5, 2'd0, 1'b1);
    test_random(40);
    test_back_to_back();
    test_reset_mid();
    test_directed("recover", 31'h80, 5'h14, 5'h18, '0, 2'd1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
